// File: rtl/soin_btb_ras_predictor.sv
// Fetch-side predictor: tagged BTB with 2-bit counters and a circular RAS.
// A clear sweep invalidates the table after reset before predictions start.
module soin_bpredictor_decode (
    input  logic [31:0] inst,
    output logic        is_branch,
    output logic        is_cond,
    output logic        is_call,
    output logic        is_ret
);
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       is_jal;
    logic       is_jalr;
    logic       rd_link;
    logic       rs1_link;
    logic       unused_inst;

    assign opcode      = inst[6:0];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign unused_inst = ^{inst[31:20], inst[14:12]};

    always_comb begin
        is_jal    = (opcode == 7'b1101111);
        is_jalr   = (opcode == 7'b1100111);
        is_cond   = (opcode == 7'b1100011);
        rd_link   = (rd == 5'd1) || (rd == 5'd5);
        rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
        is_branch = is_jal | is_jalr | is_cond;
        is_call   = (is_jal | is_jalr) & rd_link;
        is_ret    = is_jalr & rs1_link & (rd == 5'd0);
    end
endmodule

module soin_btb_ras_predictor #(
    parameter int IDX_W       = 8,
    parameter int TAG_W       = 8,
    parameter int RAS_DEPTH_L = 4,
    parameter int META_W      = IDX_W + 3 + RAS_DEPTH_L
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       fetch_pc,
    input  logic [31:0]       fetch_inst,
    input  logic              fetch_redirect,
    input  logic [31:0]       fetch_redirect_pc,
    output logic              p_dir,
    output logic [31:0]       p_target,
    output logic [META_W-1:0] p_meta,
    input  logic              upd,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_target,
    input  logic              upd_dir,
    input  logic [META_W-1:0] upd_meta,
    input  logic              recover_ras,
    output logic              init_done
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int RAS_N   = 1 << RAS_DEPTH_L;
    localparam int TAG_LO  = IDX_W + 2;
    localparam int TAG_HI  = IDX_W + TAG_W + 1;

    typedef enum logic {S_CLEAR, S_RUN} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [31:0]            pc_r_q, pc_r_d;
    logic [RAS_DEPTH_L-1:0] ras_ptr_q, ras_ptr_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [TAG_W-1:0]       rd_tag_q, rd_tag_d;
    logic [1:0]             rd_ctr_q, rd_ctr_d;
    logic [29:0]            rd_tgt_q, rd_tgt_d;

    logic                   valid_mem [ENTRIES];
    logic [TAG_W-1:0]       tag_mem   [ENTRIES];
    logic [1:0]             ctr_mem   [ENTRIES];
    logic [29:0]            tgt_mem   [ENTRIES];
    logic [31:0]            ras_mem   [RAS_N];

    logic                   is_branch, is_cond, is_call, is_ret;
    logic                   run, hit;
    logic [31:0]            seq_pc;
    logic [IDX_W-1:0]       lk_idx;
    logic                   ras_push;
    logic [RAS_DEPTH_L-1:0] ras_wr_idx;
    logic                   wr_en, wr_valid, wr_tgt_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [TAG_W-1:0]       wr_tag;
    logic [1:0]             wr_ctr, meta_ctr;
    logic                   unused_bits;

    soin_bpredictor_decode u_dec (
        .inst      (fetch_inst),
        .is_branch (is_branch),
        .is_cond   (is_cond),
        .is_call   (is_call),
        .is_ret    (is_ret)
    );

    assign run         = (state_q == S_RUN);
    assign init_done   = run;
    assign seq_pc      = pc_r_q + 32'd4;
    assign lk_idx      = fetch_pc[IDX_W+1:2];
    assign ras_wr_idx  = ras_ptr_q + 1'b1;
    assign meta_ctr    = upd_meta[IDX_W+2:IDX_W+1];
    assign unused_bits = ^{pc_r_q[31:TAG_HI+1], pc_r_q[1:0],
                           upd_pc[31:TAG_HI+1], upd_pc[IDX_W+1:0],
                           fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                           upd_target[1:0]};

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (!run) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {IDX_W{1'b1}}) state_d = S_RUN;
        end
    end

    // Registered read port; a stalled fetch keeps the previous lookup.
    always_comb begin
        pc_r_d     = pc_r_q;
        rd_valid_d = rd_valid_q;
        rd_tag_d   = rd_tag_q;
        rd_ctr_d   = rd_ctr_q;
        rd_tgt_d   = rd_tgt_q;
        if (!stall) begin
            pc_r_d     = fetch_pc;
            rd_valid_d = valid_mem[lk_idx];
            rd_tag_d   = tag_mem[lk_idx];
            rd_ctr_d   = ctr_mem[lk_idx];
            rd_tgt_d   = tgt_mem[lk_idx];
        end
    end

    always_comb begin
        hit      = run & rd_valid_q & (rd_tag_q == pc_r_q[TAG_HI:TAG_LO]);
        p_dir    = run & is_branch & (is_ret | (hit & (!is_cond | rd_ctr_q[1])));
        p_meta   = {ras_ptr_q, rd_ctr_q, hit, pc_r_q[IDX_W+1:2]};
        p_target = seq_pc;
        if (fetch_redirect) p_target = fetch_redirect_pc;
        else if (!p_dir)    p_target = seq_pc;
        else if (is_ret)    p_target = ras_mem[ras_ptr_q];
        else                p_target = {rd_tgt_q, 2'b00};
    end

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_push  = 1'b0;
        if (run) begin
            if (recover_ras) begin
                ras_ptr_d = upd_meta[META_W-1 -: RAS_DEPTH_L];
            end else if (!stall && is_call) begin
                ras_push  = 1'b1;
                ras_ptr_d = ras_wr_idx;
            end else if (!stall && is_ret) begin
                ras_ptr_d = ras_ptr_q - 1'b1;
            end
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = clr_cnt_q;
        wr_valid  = 1'b0;
        wr_tag    = '0;
        wr_ctr    = 2'b00;
        wr_tgt_en = 1'b0;
        if (!run) begin
            wr_en = reset;
        end else if (upd) begin
            wr_idx = upd_meta[IDX_W-1:0];
            wr_tag = upd_pc[TAG_HI:TAG_LO];
            if (upd_meta[IDX_W]) begin
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tgt_en = upd_dir;
                if (upd_dir) wr_ctr = (meta_ctr == 2'b11) ? 2'b11 : meta_ctr + 2'b01;
                else         wr_ctr = (meta_ctr == 2'b00) ? 2'b00 : meta_ctr - 2'b01;
            end else if (upd_dir) begin
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tgt_en = 1'b1;
                wr_ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= '0;
            pc_r_q     <= '0;
            ras_ptr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= '0;
            rd_ctr_q   <= 2'b00;
            rd_tgt_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            pc_r_q     <= pc_r_d;
            ras_ptr_q  <= ras_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_tag_q   <= rd_tag_d;
            rd_ctr_q   <= rd_ctr_d;
            rd_tgt_q   <= rd_tgt_d;
        end
    end

    // Storage arrays are not reset; the clear sweep invalidates them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_idx] <= wr_valid;
            tag_mem[wr_idx]   <= wr_tag;
            ctr_mem[wr_idx]   <= wr_ctr;
        end
        if (wr_tgt_en) tgt_mem[wr_idx] <= upd_target[31:2];
        if (ras_push) ras_mem[ras_wr_idx] <= seq_pc;
    end
endmodule
